bin_bcd_converter: RTL
======================

# bin_bcd_converter

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that turns a binary value such as the game score or timer into per-digit 4-bit codes for the `bdd` hex display decoders. It sits upstream of one `bdd` instance per digit, so the decoders only ever see digit codes 0–9, or the error code. One conversion takes a fixed WIDTH cycles and uses a start/busy/done handshake.

## Interface
- `WIDTH`, 14: binary input width. Legal range is 1–32.
- `DIGITS`, 4: number of BCD digits produced. 10**DIGITS must be representable in 33 bits.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low. Low clears all state immediately.
- `start`  in  1: request a conversion. Sampled only while `busy`=0.
- `binary`  in  WIDTH: value to convert. Captured in the cycle `start` is accepted.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse; `bcd` and `overflow` are updated in this cycle.
- `bcd`  out  4*DIGITS: digit k occupies bits [4k+3:4k]; digit 0 is the least significant.
- `overflow`  out  1: the last captured value was ≥ 10**DIGITS.
- `blank`  out  DIGITS: leading-zero mask, one bit per digit. See Configuration.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - SHIFT: `busy`=1, with a cycle counter running 0..WIDTH-1.
- IDLE → SHIFT on `start`=1. In that cycle:
  - capture `binary` into the shift register;
  - clear the scratch register (4*DIGITS bits);
  - latch `ovf_pending` = (`binary` ≥ 10**DIGITS).
- SHIFT, each cycle:
  - each scratch digit ≥ 5 gets +3, via `bcd_add3`;
  - then {scratch, shift} shifts left by 1.
- SHIFT → IDLE after the WIDTH-th shift. On that edge:
  - `done` is registered high for one cycle;
  - `bcd` = scratch and `overflow` = 0, or, if `ovf_pending`, every digit = 4'hF and `overflow` = 1. The 4'hF code makes `bdd` show its error pattern.
- Truncating the scratch register is safe: in-range values never carry past digit DIGITS-1, and out-of-range values are replaced.
- `start` while `busy`=1 is ignored. It is neither queued nor allowed to alter the captured value.
- `bcd`, `overflow` and `blank` hold their values until the next `done`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `overflow`=0, `bcd`=0, `blank`=0;
  - FSM in IDLE, counter = 0.
- Latency:
  - `start` is sampled at edge N;
  - `busy` is high from after edge N through edge N+WIDTH;
  - `done` is high and `bcd` is valid in the cycle after edge N+WIDTH;
  - total: WIDTH+1 cycles from the start cycle to `done`.
- Back-to-back conversions: `start` is accepted in the same cycle `done` is high, because `busy` is already 0. Sustained throughput is one result per WIDTH+1 cycles.
- Reset asserted mid-conversion:
  - the conversion is aborted and all outputs return to reset values asynchronously;
  - no `done` is produced;
  - after release, the block waits in IDLE for a new `start`.
- WIDTH=1: a single SHIFT cycle; the result is 0 or 1.

## Configuration
- Macro `BCD_LEADING_BLANK_EN`.
- Defined:
  - `blank[k]`=1 when digit k and all higher digits are 0, for every k ≥ 1;
  - `blank[0]` is always 0, so the value zero shows a single "0";
  - `blank` is registered on `done` together with `bcd`;
  - `blank` is all 0 on overflow.
- Undefined: `blank` is constant 0 and no suppression logic is synthesised.

## Structure
- Package `wam_display_pkg` holds:
  - the FSM state enum (IDLE, SHIFT);
  - `BCD_ERR_CODE` = 4'hF;
  - `BCD_DIGIT_W` = 4.
- Sub-module `bcd_add3`: combinational 4-bit digit correction (digit ≥ 5 → +3). It is instantiated DIGITS times by a generate loop.
- Counter width is $clog2(WIDTH+1).

## Test plan
All scenarios use WIDTH=14, DIGITS=4.
- `binary`=0, start pulse → after 15 cycles `done`=1, `bcd`=16'h0000, `overflow`=0. With the macro, `blank`=4'b1110.
- `binary`=9999 → `bcd`=16'h9999, `overflow`=0, `blank`=0, `done` exactly 15 cycles after start.
- `binary`=10000 and then 16383 → `bcd`=16'hFFFF, `overflow`=1.
- `binary`=42, start; re-pulse start with `binary`=7 during `busy` → `bcd`=16'h0042 and only one `done` pulse. Start with 7 in the `done` cycle → next result is 16'h0007.
- Start with 1234; drive `reset` low at cycle 6 → outputs are 0 immediately and no `done` appears. After release, start with 0305 → `bcd`=16'h0305, and with the macro `blank`=4'b1000.

Source files
------------

// File: rtl/wam_display_pkg.sv
// Shared types and constants for the score/timer display path.
// Used by bin_bcd_converter and bcd_add3.
package wam_display_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int         BCD_DIGIT_W  = 4;
    localparam logic [3:0] BCD_ERR_CODE = 4'hF;

    // 33-bit power of ten, used for the out-of-range threshold
    function automatic logic [32:0] pow10(input int n);
        logic [32:0] r;
        r = 33'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 33'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the
// next left shift so that it carries correctly into the next decade.
module bcd_add3
    import wam_display_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one result per WIDTH+1 cycles.
// Define BCD_LEADING_BLANK_EN to produce the leading-zero blanking mask.
module bin_bcd_converter
    import wam_display_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int          SW    = BCD_DIGIT_W * DIGITS;
    localparam int          CW    = $clog2(WIDTH + 1);
    localparam logic [32:0] LIMIT = pow10(DIGITS);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic              ovfPending_q, ovfPending_d;
    logic              done_q, done_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic              overflow_q, overflow_d;

    logic [SW-1:0]     adjusted;
    logic [SW-1:0]     scratchShift;
    logic [32:0]       binExt;
    logic              lastShift;

    for (genvar k = 0; k < DIGITS; k++) begin : gAdd3
        bcd_add3 uAdd3 (
            .digit_i(scratch_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .digit_o(adjusted[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // The bit shifted out of the top digit is dropped: in-range values never
    // produce it and out-of-range results are replaced by the error code.
    assign scratchShift = SW'({adjusted, shift_q[WIDTH-1]});
    assign binExt       = 33'(binary);
    assign lastShift    = (cnt_q == CW'(WIDTH - 1));

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blankNext;

    // Digit k is blanked when it and every digit above it are zero; digit 0 never is
    always_comb begin
        logic allZero;
        blankNext = '0;
        allZero   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            allZero      = allZero && (scratchShift[BCD_DIGIT_W*k +: BCD_DIGIT_W] == 4'd0);
            blankNext[k] = allZero;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == SHIFT && lastShift) begin
            blank_d = ovfPending_q ? '0 : blankNext;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            scratch_q    <= '0;
            ovfPending_q <= 1'b0;
            done_q       <= 1'b0;
            bcd_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            scratch_q    <= scratch_d;
            ovfPending_q <= ovfPending_d;
            done_q       <= done_d;
            bcd_q        <= bcd_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        scratch_d    = scratch_q;
        ovfPending_d = ovfPending_q;
        done_d       = 1'b0;
        bcd_d        = bcd_q;
        overflow_d   = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SHIFT;
                    cnt_d        = '0;
                    shift_d      = binary;
                    scratch_d    = '0;
                    ovfPending_d = (binExt >= LIMIT);
                end
            end
            SHIFT: begin
                shift_d   = shift_q << 1;
                scratch_d = scratchShift;
                cnt_d     = cnt_q + 1'b1;
                if (lastShift) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (ovfPending_q) begin
                        bcd_d      = {DIGITS{BCD_ERR_CODE}};
                        overflow_d = 1'b1;
                    end else begin
                        bcd_d      = scratchShift;
                        overflow_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
